// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles every non-clock/reset signal of the fetch stage.
//   ROM side     : rom_addr (to ROM), rom_data (combinational ROM word back)
//   Decode side  : instr, instr_pc, instr_valid (to decode), instr_ready (back)
//   Execute side : redirect_valid, redirect_pc, halt_req (to fetch)
//   Status       : halted, retired_cnt (from fetch)
// Modports:
//   master - the fetch unit itself
//   slave  - the surrounding ROM / decode / execute environment
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt_req;
  logic              halted;
  logic [15:0]       retired_cnt;

  modport master (
    output rom_addr,
    input  rom_data,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_pc,
    input  halt_req,
    output halted,
    output retired_cnt
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output redirect_valid,
    output redirect_pc,
    output halt_req,
    input  halted,
    input  retired_cnt
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage in front of a combinational instruction ROM. Owns the PC,
// captures {pc, word} into a 2-entry FIFO toward decode, honours redirects
// (flush + new PC) and a halt request, and counts instructions taken by decode.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - instr_fetch_unit_if.master (ROM, decode, execute and status signals)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        count_q, count_d;
  // Entry 0 is always the head; entry 1 is only meaningful when count_q == 2.
  logic [ADDR_W-1:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
  logic [DATA_W-1:0] e0_word_q, e0_word_d, e1_word_q, e1_word_d;
  logic [15:0]       retired_q, retired_d;
  logic              pop_s;
  logic              push_s;
  logic              valid_s;

  assign valid_s = (count_q != 2'd0);

  // Drive outputs straight from registers; head reads as zero when empty.
  always_comb begin
    bus.rom_addr    = pc_q;
    bus.instr_valid = valid_s;
    bus.halted      = (state_q == ST_HALTED);
    bus.retired_cnt = retired_q;
    if (valid_s) begin
      bus.instr    = e0_word_q;
      bus.instr_pc = e0_pc_q;
    end else begin
      bus.instr    = '0;
      bus.instr_pc = '0;
    end
  end

  // Next-state logic: redirect > halt > normal fetch; pops always counted.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    e0_pc_d   = e0_pc_q;
    e0_word_d = e0_word_q;
    e1_pc_d   = e1_pc_q;
    e1_word_d = e1_word_q;

    pop_s  = valid_s & bus.instr_ready;
    // A pop frees a slot in the same cycle, which keeps full-rate streaming.
    push_s = (state_q == ST_RUN) & ~bus.redirect_valid & ~bus.halt_req &
             ((count_q != 2'd2) | pop_s);

    if (pop_s) begin
      retired_d = retired_q + 16'd1;
    end else begin
      retired_d = retired_q;
    end

    if (bus.redirect_valid) begin
      // Decode may still consume the head this cycle; only the entries go.
      state_d = ST_RUN;
      pc_d    = bus.redirect_pc;
      count_d = 2'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.halt_req) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_RUN;
      endcase

      if (push_s) begin
        pc_d = pc_q + ADDR_W'(1);
      end else begin
        pc_d = pc_q;
      end

      // rom_data is only looked at on push cycles.
      case ({push_s, pop_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_pc_d   = pc_q;
            e0_word_d = bus.rom_data;
          end else begin
            e1_pc_d   = pc_q;
            e1_word_d = bus.rom_data;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_pc_d   = e1_pc_q;
          e0_word_d = e1_word_q;
          count_d   = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            e0_pc_d   = e1_pc_q;
            e0_word_d = e1_word_q;
            e1_pc_d   = pc_q;
            e1_word_d = bus.rom_data;
          end else begin
            e0_pc_d   = pc_q;
            e0_word_d = bus.rom_data;
          end
          count_d = count_q;
        end
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      count_q   <= 2'd0;
      e0_pc_q   <= '0;
      e0_word_q <= '0;
      e1_pc_q   <= '0;
      e1_word_q <= '0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      e0_pc_q   <= e0_pc_d;
      e0_word_q <= e0_word_d;
      e1_pc_q   <= e1_pc_d;
      e1_word_q <= e1_word_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. ROM model returns address + 0x1000.
// Inputs change 1 ns after each rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic clk_s;
  logic rst_n_s;
  int   check_cnt_r;
  int   pass_cnt_r;

  instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) bus_if ();

  instr_fetch_unit #(
    .ADDR_W   (8),
    .DATA_W   (16),
    .RESET_PC (8'h00)
  ) u_dut (
    .clk   (clk_s),
    .rst_n (rst_n_s),
    .bus   (bus_if.master)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk_s = 1'b0;
    forever #5 clk_s = ~clk_s;
  end

  // Combinational ROM: word = 0x1000 + address.
  always_comb begin
    bus_if.rom_data = 16'h1000 + {8'h00, bus_if.rom_addr};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt_r = check_cnt_r + 1;
    if (obs === exp) begin
      pass_cnt_r = pass_cnt_r + 1;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_s);
    #1;
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    check_cnt_r = 0;
    pass_cnt_r  = 0;
    rst_n_s               = 1'b0;
    bus_if.instr_ready    = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 8'h00;
    bus_if.halt_req       = 1'b0;
    step();
    step();

    // Reset state
    check_eq("rst_valid",   32'(bus_if.instr_valid), 32'd0);
    check_eq("rst_instr",   32'(bus_if.instr),       32'd0);
    check_eq("rst_pc",      32'(bus_if.instr_pc),    32'd0);
    check_eq("rst_romaddr", 32'(bus_if.rom_addr),    32'd0);
    check_eq("rst_halted",  32'(bus_if.halted),      32'd0);
    check_eq("rst_retired", 32'(bus_if.retired_cnt), 32'd0);

    // 1: stream with continuous ready, one instruction per cycle
    rst_n_s            = 1'b1;
    bus_if.instr_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check_eq("t1_valid", 32'(bus_if.instr_valid), 32'd1);
      check_eq("t1_pc",    32'(bus_if.instr_pc),    32'(i));
      check_eq("t1_instr", 32'(bus_if.instr),       32'(16'h1000 + 16'(i)));
      step();
    end
    check_eq("t1_retired", 32'(bus_if.retired_cnt), 32'd3);

    // 2: backpressure from PC 3 for 5 cycles
    bus_if.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
    end
    check_eq("t2_head",    32'(bus_if.instr_pc),    32'h03);
    check_eq("t2_romaddr", 32'(bus_if.rom_addr),    32'h05);
    check_eq("t2_retired", 32'(bus_if.retired_cnt), 32'd3);
    bus_if.instr_ready = 1'b1;
    step();
    check_eq("t2_drain4",  32'(bus_if.instr_pc),    32'h04);
    step();
    check_eq("t2_drain5",  32'(bus_if.instr_pc),    32'h05);
    check_eq("t2_retired2", 32'(bus_if.retired_cnt), 32'd5);

    // 3: redirect to 0x80 with 2 entries held and a pop in the same cycle
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 8'h80;
    step();
    bus_if.redirect_valid = 1'b0;
    check_eq("t3_valid",   32'(bus_if.instr_valid), 32'd0);
    check_eq("t3_romaddr", 32'(bus_if.rom_addr),    32'h80);
    check_eq("t3_retired", 32'(bus_if.retired_cnt), 32'd6);
    step();
    check_eq("t3_pc",      32'(bus_if.instr_pc),    32'h80);
    check_eq("t3_instr",   32'(bus_if.instr),       32'h1080);

    // 4: redirect to 0xFE, PC wraps without stalling
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 8'hFE;
    step();
    bus_if.redirect_valid = 1'b0;
    step();
    check_eq("t4_pc_fe",    32'(bus_if.instr_pc), 32'hFE);
    check_eq("t4_instr_fe", 32'(bus_if.instr),    32'h10FE);
    step();
    check_eq("t4_pc_ff",    32'(bus_if.instr_pc), 32'hFF);
    step();
    check_eq("t4_pc_00",    32'(bus_if.instr_pc), 32'h00);
    check_eq("t4_instr_00", 32'(bus_if.instr),    32'h1000);
    step();
    check_eq("t4_pc_01",    32'(bus_if.instr_pc), 32'h01);
    check_eq("t4_retired",  32'(bus_if.retired_cnt), 32'd10);

    // 5: halt at PC 0x10 with 0x0E, 0x0F buffered
    bus_if.instr_ready    = 1'b0;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 8'h0E;
    step();
    bus_if.redirect_valid = 1'b0;
    step();
    step();
    check_eq("t5_romaddr", 32'(bus_if.rom_addr), 32'h10);
    check_eq("t5_head",    32'(bus_if.instr_pc), 32'h0E);
    bus_if.halt_req = 1'b1;
    step();
    bus_if.halt_req = 1'b0;
    check_eq("t5_halted",   32'(bus_if.halted),      32'd1);
    check_eq("t5_pcfrozen", 32'(bus_if.rom_addr),    32'h10);
    check_eq("t5_valid",    32'(bus_if.instr_valid), 32'd1);
    bus_if.instr_ready = 1'b1;
    step();
    check_eq("t5_drain",    32'(bus_if.instr_pc),    32'h0F);
    step();
    check_eq("t5_empty",    32'(bus_if.instr_valid), 32'd0);
    bus_if.halt_req = 1'b1;
    step();
    step();
    step();
    bus_if.halt_req = 1'b0;
    check_eq("t5_stay_empty", 32'(bus_if.instr_valid), 32'd0);
    check_eq("t5_stay_pc",    32'(bus_if.rom_addr),    32'h10);
    check_eq("t5_stay_halt",  32'(bus_if.halted),      32'd1);
    check_eq("t5_retired",    32'(bus_if.retired_cnt), 32'd12);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 8'h3B;
    step();
    bus_if.redirect_valid = 1'b0;
    check_eq("t5_resume_halt", 32'(bus_if.halted),   32'd0);
    check_eq("t5_resume_addr", 32'(bus_if.rom_addr), 32'h3B);
    step();
    check_eq("t5_resume_pc",    32'(bus_if.instr_pc), 32'h3B);
    check_eq("t5_resume_instr", 32'(bus_if.instr),    32'h103B);

    // 6: reset with full buffer and a redirect pending
    bus_if.instr_ready = 1'b0;
    step();
    check_eq("t6_full_head", 32'(bus_if.instr_pc), 32'h3B);
    check_eq("t6_full_addr", 32'(bus_if.rom_addr), 32'h3D);
    rst_n_s               = 1'b0;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 8'h55;
    bus_if.instr_ready    = 1'b1;
    step();
    check_eq("t6_valid",   32'(bus_if.instr_valid), 32'd0);
    check_eq("t6_instr",   32'(bus_if.instr),       32'd0);
    check_eq("t6_romaddr", 32'(bus_if.rom_addr),    32'd0);
    check_eq("t6_retired", 32'(bus_if.retired_cnt), 32'd0);
    check_eq("t6_halted",  32'(bus_if.halted),      32'd0);
    rst_n_s               = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.instr_ready    = 1'b0;
    step();
    check_eq("t6_restart_pc",    32'(bus_if.instr_pc), 32'h00);
    check_eq("t6_restart_instr", 32'(bus_if.instr),    32'h1000);

    $display("%0d/%0d checks passed", pass_cnt_r, check_cnt_r);
    $finish;
  end

endmodule
